// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed byte stream into little-endian words
// and writes them to instruction memory from BASE_ADDR, holding the CPU until done.
module imem_loader #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'hBFC00000,
  parameter int                       MEM_BYTES     = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic                      wr_en,
  output logic [ADDRESS_WIDTH-1:0]  wr_addr,
  output logic [4*DATA_WIDTH-1:0]   wr_data,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      len_lo_q, len_lo_d;
  logic [15:0]                remaining_q, remaining_d;
  logic [15:0]                word_idx_q, word_idx_d;
  logic [1:0]                 byte_cnt_q, byte_cnt_d;
  logic [4*DATA_WIDTH-1:0]    word_q, word_d;
  logic                       rx_ready_q, rx_ready_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [4*DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                       cpu_hold_q, cpu_hold_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                       accept;
  logic [2*DATA_WIDTH-1:0]    len;

  assign accept = rx_valid && rx_ready_q;
  assign len    = {rx_data, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    remaining_d = remaining_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        len_lo_d = rx_data;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        if (len == '0 || len[1:0] != 2'b00 || int'(len) > MEM_BYTES) begin
          state_d = S_ERROR;
        end else begin
          state_d     = S_PAYLOAD;
          remaining_d = 16'(len);
          word_idx_d  = '0;
          byte_cnt_d  = '0;
        end
      end
      S_PAYLOAD: if (accept) begin
        word_d[byte_cnt_q*DATA_WIDTH +: DATA_WIDTH] = rx_data;
        remaining_d = remaining_q - 16'd1;
        byte_cnt_d  = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          // Launch the write straight from the last byte so wr_en lands next cycle.
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + ADDRESS_WIDTH'({word_idx_q, 2'b00});
          wr_data_d = {rx_data, word_q[3*DATA_WIDTH-1:0]};
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (remaining_q == '0) ? S_DONE : S_PAYLOAD;
      end
      default: state_d = S_IDLE;
    endcase
    rx_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_PAYLOAD);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      remaining_q <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      remaining_q <= remaining_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load timing, stalls, header rejects, reset and restart.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] wa[$], wd[$];
  int          wc[$];
  logic        wr_rdy[$];
  logic [7:0]  img[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled mid-cycle.
  always @(negedge clk) if (wr_en) begin
    wa.push_back(wr_addr); wd.push_back(wr_data); wc.push_back(cyc); wr_rdy.push_back(rx_ready);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wc.delete(); wr_rdy.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a negedge; leaves rx_valid high after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic rdy;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 200; t++) begin
      rdy = rx_ready;
      @(negedge clk);
      if (rdy) return;
    end
    chk("rx_ready_timeout", rx_ready, 1'b1);
  endtask

  task automatic send_img(input bit gaps);
    foreach (img[i]) send_byte(img[i], gaps);
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(output int c);
    c = -1;
    for (int t = 0; t < 50; t++) begin
      if (done || error) begin c = cyc; return; end
      @(negedge clk);
    end
    chk("wait_end_timeout", {done, error}, 2'b10);
  endtask

  task automatic chk_img1(input string tag);
    chk({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'hBFC00000);
      chk({tag, "_d0"}, wd[0], 32'h00A00513);
      chk({tag, "_a1"}, wa[1], 32'hBFC00004);
      chk({tag, "_d1"}, wd[1], 32'h0000006F);
      chk({tag, "_rdy0"}, wr_rdy[0], 1'b0);
      chk({tag, "_rdy1"}, wr_rdy[1], 1'b0);
    end
  endtask

  task automatic hdr_err(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    pulse_start();
    clr_log();
    img = '{lo, hi};
    send_img(1'b0);
    chk({tag, "_err"}, error, 1'b1);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, wa.size(), 0);
    chk({tag, "_err_stays"}, error, 1'b1);
  endtask

  initial begin
    int t0, tend;
    logic [31:0] exp_last;
    repeat (2) @(negedge clk);
    chk("rst_rdy", rx_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_addr", wr_addr, 32'hBFC00000);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Gap-free image: exact cycle positions relative to the start edge.
    pulse_start();
    t0 = cyc;
    chk("lenlo_rdy", rx_ready, 1'b1);
    clr_log();
    img = '{8'h08, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_img(1'b0);
    wait_end(tend);
    chk_img1("img1");
    if (wc.size() == 2) begin
      chk("img1_wr0_cyc", wc[0] - t0, 6);
      chk("img1_wr1_cyc", wc[1] - t0, 11);
    end
    chk("img1_done_cyc", tend - t0, 12);
    chk("img1_done", done, 1'b1);
    chk("img1_hold", cpu_hold, 1'b0);
    chk("img1_rdy", rx_ready, 1'b0);

    // Restart from DONE with a single-word image.
    pulse_start();
    chk("restart_hold", cpu_hold, 1'b1);
    chk("restart_done", done, 1'b0);
    clr_log();
    img = '{8'h04, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_img(1'b0);
    wait_end(tend);
    chk("one_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("one_a0", wa[0], 32'hBFC00000);
      chk("one_d0", wd[0], 32'hDEADBEEF);
    end
    chk("one_done", done, 1'b1);

    // Same image as before with random stalls.
    pulse_start();
    clr_log();
    img = '{8'h08, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_img(1'b1);
    wait_end(tend);
    chk_img1("gaps");
    chk("gaps_done", done, 1'b1);

    hdr_err("len6", 8'h06, 8'h00);
    hdr_err("len0", 8'h00, 8'h00);
    hdr_err("len4100", 8'h04, 8'h10);

    // start mid-payload must be ignored.
    pulse_start();
    chk("errclr", error, 1'b0);
    clr_log();
    img = '{8'h08, 8'h00, 8'h13, 8'h05};
    send_img(1'b0);
    pulse_start();
    chk("pstart_rdy", rx_ready, 1'b1);
    chk("pstart_err", error, 1'b0);
    chk("pstart_nwr", wa.size(), 0);
    img = '{8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_img(1'b0);
    wait_end(tend);
    chk_img1("pstart");

    // Async reset after 5 payload bytes.
    pulse_start();
    clr_log();
    img = '{8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_img(1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rdy", rx_ready, 1'b0);
    chk("arst_wr_en", wr_en, 1'b0);
    chk("arst_addr", wr_addr, 32'hBFC00000);
    chk("arst_data", wr_data, 32'h0);
    chk("arst_hold", cpu_hold, 1'b1);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    clr_log();
    img = '{8'h08, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_img(1'b0);
    wait_end(tend);
    chk_img1("arst");
    chk("arst_fin_done", done, 1'b1);

    // Maximal image: 4096 bytes, byte i = i[7:0].
    pulse_start();
    clr_log();
    img = '{8'h00, 8'h10};
    for (int i = 0; i < 4096; i++) img.push_back(8'(i));
    send_img(1'b0);
    wait_end(tend);
    chk("max_nwr", wa.size(), 1024);
    if (wa.size() == 1024) begin
      chk("max_a1", wa[1], 32'hBFC00004);
      chk("max_d1", wd[1], 32'h07060504);
      exp_last = 32'hFFFEFDFC;
      chk("max_alast", wa[1023], 32'hBFC00FFC);
      chk("max_dlast", wd[1023], exp_last);
    end
    chk("max_done", done, 1'b1);
    chk("max_hold", cpu_hold, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
